// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO; optional FIFO_PEAK_EN adds the peak_usedw high-water output.
// Latency: usedw/flags one cycle after the request; rd_data one cycle after a read (SHOW_AHEAD=0) or head word live (SHOW_AHEAD=1).
// Backpressure: wr_full/rd_empty gate acceptance; rejected requests leave state untouched and set sticky overflow/underflow.
module fifo_sync_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int AFULL_TH   = 2**ADDR_W-2,
  parameter int AEMPTY_TH  = 2,
  parameter int SHOW_AHEAD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_full,
  output logic              rd_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_PEAK_EN
  ,
  output logic [ADDR_W:0]   peak_usedw
`endif
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AFULL_V   = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_V  = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0]   usedw_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic              wr_acc, rd_acc, ovf_evt, udf_evt;

  always_comb begin
    wr_acc     = wr_req & ~wr_full;
    rd_acc     = rd_req & ~rd_empty;
    ovf_evt    = wr_req & wr_full;
    udf_evt    = rd_req & rd_empty;
    rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
    usedw_nxt  = usedw;
    if (wr_acc && !rd_acc)
      usedw_nxt = usedw + CNT_ONE;
    else if (rd_acc && !wr_acc)
      usedw_nxt = usedw - CNT_ONE;
    // Next head comes straight from wr_data when the only valid word next cycle is the one being written now.
    head_nxt = mem[rd_ptr_nxt];
    if (usedw == '0 || (usedw == CNT_ONE && rd_acc))
      head_nxt = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      wr_full      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr       <= rd_ptr_nxt;
      usedw        <= usedw_nxt;
      wr_full      <= (usedw_nxt == CNT_FULL);
      rd_empty     <= (usedw_nxt == '0);
      almost_full  <= (usedw_nxt >= AFULL_V);
      almost_empty <= (usedw_nxt <= AEMPTY_V);
      overflow     <= ovf_evt | (overflow & ~clr_err);
      underflow    <= udf_evt | (underflow & ~clr_err);
      if (SHOW_AHEAD != 0) begin
        if (usedw_nxt != '0)
          rd_data <= head_nxt;
      end else if (rd_acc) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

`ifdef FIFO_PEAK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      peak_usedw <= '0;
    else if (clr_err)
      peak_usedw <= usedw;
    else if (usedw_nxt > peak_usedw)
      peak_usedw <= usedw_nxt;
  end
`endif

endmodule
